test_bed: RTL and testbench

//  Self-checking result monitor for the MIPS CHIP (CPU + I/D caches) simulation.
//  - Snoops the CPU's D-cache write port (word address, data, write enable).
//  - Compares answer-region writes, in order, against a golden table.
//  - Counts mismatches and measures the cycle duration of the run.
//  - Raises finish when every answer has been received.
//  - Sits beside CHIP and the two slow_memory instances; drives nothing into the design.

---
 rtl/tb_pkg.sv | 9 +
 rtl/test_bed_if.sv | 8 +
 rtl/test_bed_golden_rom.sv | 12 +
 rtl/test_bed.sv | 70 +++++++
 tb/tb_test_bed.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/tb_pkg.sv
// tb_pkg: state encodings, counter limits and golden answer table for the result monitor
package tb_pkg;
  typedef enum logic [1:0] {WAIT = 2'd0, CHECK = 2'd1, DONE = 2'd2} state_e;
  localparam logic [7:0] ERR_MAX = 8'hFF;
  localparam logic [15:0] DUR_MAX = 16'hFFFF;
  function automatic logic [31:0] golden_word(input int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'hC0FFEE00 ^ (32'(i) << 7);
  endfunction
endpackage

// File: rtl/test_bed_if.sv
// test_bed_if: snooped D-cache write port (word address, data, write enable)
interface test_bed_if;
  logic [29:0] addr;
  logic [31:0] data;
  logic wen;
  modport master(output addr, data, wen);
  modport slave(input addr, data, wen);
endinterface

// File: rtl/test_bed_golden_rom.sv
// test_bed_golden_rom: read-only ANS_NUM x 32 answer table, asynchronous read, zero outside the table
module test_bed_golden_rom
  import tb_pkg::*;
#(
  parameter int ANS_NUM = 32,
  parameter int AW = 6
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   data
);
  assign data = int'(addr) < ANS_NUM ? golden_word(int'(addr)) : '0;
endmodule

// File: rtl/test_bed.sv
// test_bed: checks answer-region D-cache writes in order against the golden table, counting errors and run cycles
module test_bed
  import tb_pkg::*;
#(
  parameter int ANS_NUM = 32,
  parameter logic [29:0] ANS_BASE = 30'h0000100
) (
  input  logic        clk,
  input  logic        rst,
  test_bed_if.slave   bus,
  output logic [7:0]  error_num,
  output logic [15:0] duration,
  output logic        finish
);
  localparam int IW = $clog2(ANS_NUM) + 1;
  localparam logic [IW-1:0] LAST = IW'(ANS_NUM - 1);
  state_e curstate_q, curstate_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0] error_num_q, error_num_d;
  logic [15:0] duration_q, duration_d;
  logic finish_q, finish_d;
  logic [31:0] gold;
  logic aw, mis;
  test_bed_golden_rom #(.ANS_NUM(ANS_NUM), .AW(IW)) u_rom (.addr(idx_q), .data(gold));
  assign aw = bus.wen && bus.addr >= ANS_BASE && bus.addr < ANS_BASE + 30'(ANS_NUM);
  // idx stays 0 in WAIT, so the same compare qualifies the first answer
  assign mis = bus.addr != ANS_BASE + 30'(idx_q) || bus.data != gold;
  always_comb begin
    curstate_d = curstate_q;
    idx_d = idx_q;
    error_num_d = error_num_q;
    duration_d = duration_q;
    case (curstate_q)
      WAIT: if (aw && !mis) begin
        curstate_d = ANS_NUM == 1 ? DONE : CHECK;
        idx_d = IW'(1);
        duration_d = '0;
      end
      CHECK: begin
        duration_d = duration_q == DUR_MAX ? duration_q : duration_q + 16'd1;
        if (aw) begin
          error_num_d = mis && error_num_q != ERR_MAX ? error_num_q + 8'd1 : error_num_q;
          idx_d = idx_q + IW'(1);
          curstate_d = idx_q == LAST ? DONE : CHECK;
        end
      end
      DONE: ;
      default: curstate_d = WAIT;
    endcase
    finish_d = curstate_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      curstate_q <= WAIT;
      idx_q <= '0;
      error_num_q <= '0;
      duration_q <= '0;
      finish_q <= 1'b0;
    end else begin
      curstate_q <= curstate_d;
      idx_q <= idx_d;
      error_num_q <= error_num_d;
      duration_q <= duration_d;
      finish_q <= finish_d;
    end
  end
  assign error_num = error_num_q;
  assign duration = duration_q;
  assign finish = finish_q;
endmodule

// File: tb/tb_test_bed.sv
// tb_test_bed: directed and randomized checks of test_bed against a behavioural answer-checking model
module tb_test_bed;
  import tb_pkg::*;
  localparam logic [29:0] BASE = 30'h0000100;
  logic clk = 1'b0;
  logic rst = 1'b1;
  test_bed_if bus_a();
  test_bed_if bus_b();
  logic [7:0] err_a, err_b;
  logic [15:0] dur_a, dur_b;
  logic fin_a, fin_b;
  int checks = 0;
  int fails = 0;
  int n [2] = '{4, 300};
  bit st [2];
  bit dn [2];
  int nx [2];
  int me [2];
  int md [2];

  test_bed #(.ANS_NUM(4), .ANS_BASE(BASE)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .error_num(err_a), .duration(dur_a), .finish(fin_a));
  test_bed #(.ANS_NUM(300), .ANS_BASE(BASE)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .error_num(err_b), .duration(dur_b), .finish(fin_b));

  always #5 clk = ~clk;

  task automatic step(input int k, input logic [29:0] a, input logic [31:0] d, input logic w);
    int off;
    bit aw;
    off = int'(a) - int'(BASE);
    aw = w && off >= 0 && off < n[k];
    if (rst) begin
      st[k] = 0; dn[k] = 0; nx[k] = 0; me[k] = 0; md[k] = 0;
    end else if (!dn[k] && st[k]) begin
      md[k] = md[k] < 65535 ? md[k] + 1 : 65535;
      if (aw) begin
        if (off != nx[k] || d != golden_word(nx[k])) me[k] = me[k] < 255 ? me[k] + 1 : 255;
        nx[k]++;
        if (nx[k] == n[k]) dn[k] = 1;
      end
    end else if (!dn[k] && aw && off == 0 && d == golden_word(0)) begin
      st[k] = 1; nx[k] = 1; md[k] = 0;
      if (n[k] == 1) dn[k] = 1;
    end
  endtask

  task automatic cyc(input int k, input logic [29:0] a, input logic [31:0] d, input logic w);
    if (k == 0) begin
      bus_a.addr = a; bus_a.data = d; bus_a.wen = w; bus_b.wen = 1'b0;
    end else begin
      bus_b.addr = a; bus_b.data = d; bus_b.wen = w; bus_a.wen = 1'b0;
    end
    @(posedge clk);
    step(0, bus_a.addr, bus_a.data, bus_a.wen);
    step(1, bus_b.addr, bus_b.data, bus_b.wen);
    #1;
    bus_a.wen = 1'b0;
    bus_b.wen = 1'b0;
  endtask

  task automatic idle(input int c);
    repeat (c) cyc(0, '0, '0, 1'b0);
  endtask

  task automatic ans(input int k, input int i, input bit good);
    cyc(k, BASE + 30'(i), good ? golden_word(i) : golden_word(i) ^ 32'h1, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic chk(input int k, input string tag);
    logic [7:0] e;
    logic [15:0] du;
    logic f;
    logic [1:0] s, es;
    e = k ? err_b : err_a;
    du = k ? dur_b : dur_a;
    f = k ? fin_b : fin_a;
    s = k ? 2'(dut_b.curstate_q) : 2'(dut_a.curstate_q);
    es = dn[k] ? 2'd2 : st[k] ? 2'd1 : 2'd0;
    checks++;
    assert (e === 8'(me[k])) else begin fails++; $error("FAIL %s.error_num obs=%0d exp=%0d", tag, e, me[k]); end
    checks++;
    assert (du === 16'(md[k])) else begin fails++; $error("FAIL %s.duration obs=%0d exp=%0d", tag, du, md[k]); end
    checks++;
    assert (f === dn[k]) else begin fails++; $error("FAIL %s.finish obs=%0b exp=%0b", tag, f, dn[k]); end
    checks++;
    assert (s === es) else begin fails++; $error("FAIL %s.curstate obs=%0d exp=%0d", tag, s, es); end
  endtask

  initial begin
    bus_a.addr = '0; bus_a.data = '0; bus_a.wen = 1'b0;
    bus_b.addr = '0; bus_b.data = '0; bus_b.wen = 1'b0;
    do_reset();
    idle(10);
    chk(0, "reset_a");
    chk(1, "reset_b");
    cyc(0, BASE, golden_word(0) ^ 32'h1, 1'b1);
    cyc(0, 30'h0, golden_word(0), 1'b1);
    cyc(0, BASE + 30'd4, golden_word(0), 1'b1);
    cyc(0, BASE, golden_word(0), 1'b0);
    chk(0, "wait_wrong");
    ans(0, 0, 1);
    chk(0, "enter_check");
    for (int i = 1; i < 4; i++) begin
      idle(5);
      ans(0, i, 1);
      chk(0, "clean_run");
    end
    checks++;
    assert (dur_a === 16'd18) else begin fails++; $error("FAIL clean_duration obs=%0d exp=18", dur_a); end
    idle(3);
    ans(0, 1, 0);
    chk(0, "done_frozen");

    do_reset();
    ans(0, 0, 1);
    ans(0, 1, 0);
    cyc(0, BASE + 30'd3, golden_word(2), 1'b1);
    ans(0, 3, 0);
    chk(0, "errors");
    checks++;
    assert (err_a === 8'd3) else begin fails++; $error("FAIL error_count obs=%0d exp=3", err_a); end

    do_reset();
    ans(0, 0, 1);
    ans(0, 1, 1);
    chk(0, "pre_reset");
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk(0, "mid_reset");
    for (int i = 0; i < 4; i++) ans(0, i, 1);
    chk(0, "rerun");

    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int c = 0; c < 80; c++) begin
        logic [29:0] a;
        logic [31:0] d;
        int off;
        a = $urandom_range(0, 2) != 0 ? BASE + 30'(nx[0]) : BASE - 30'd2 + 30'($urandom_range(0, 8));
        off = int'(a) - int'(BASE);
        d = $urandom_range(0, 3) == 0 ? 32'($urandom) : golden_word(off < 0 ? 0 : off);
        cyc(0, a, d, 1'($urandom_range(0, 2) != 0));
        chk(0, "rand");
      end
    end

    do_reset();
    ans(1, 0, 1);
    for (int i = 1; i < 300; i++) ans(1, i, 0);
    chk(1, "err_sat");
    checks++;
    assert (err_b === 8'hFF) else begin fails++; $error("FAIL err_sat_value obs=%0d exp=255", err_b); end
    idle(2);
    chk(1, "err_sat_done");

    do_reset();
    ans(0, 0, 1);
    idle(70000);
    chk(0, "dur_sat");
    checks++;
    assert (dur_a === 16'hFFFF) else begin fails++; $error("FAIL dur_sat_value obs=%0h exp=ffff", dur_a); end
    for (int i = 1; i < 4; i++) ans(0, i, 1);
    chk(0, "dur_sat_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
